// File: rtl/key_matrix_scanner_if.sv
// Key event handshake: scanner presents queued events, consumer accepts with key_ready.
interface key_matrix_scanner_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       key_ready;

  modport master (output key_valid, key_code, key_pressed, input key_ready);
  modport slave  (input key_valid, key_code, key_pressed, output key_ready);
endinterface

// File: rtl/key_matrix_scanner.sv
// 4x4 key matrix scanner with per-key debounce and a 4-deep event FIFO.
// Optional auto-repeat of the last pressed key is built when KEY_MATRIX_AUTOREPEAT_EN is defined.
module key_matrix_scanner #(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_START   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [3:0]                   col_n,
  input  logic [3:0]                   row_n,
  key_matrix_scanner_if.master         ev,
  output logic [15:0]                  keys_down,
  output logic                         event_overflow
);

  localparam int SW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 4) begin : g_bad_div
    $error("SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
    $error("DEBOUNCE_SCANS must be 1..15");
  end
  if (REPEAT_START < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("REPEAT_START and REPEAT_PERIOD must be >= 1");
  end

  logic [SW-1:0]     slot_q;
  logic [1:0]        col_q;
  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        samp_q;
  logic [1:0]        samp_col_q;
  logic              samp_vld_q;
  logic [15:0][3:0]  dcnt_q;
  logic [15:0]       kd_q;

  logic              slot_last;
  logic              proc_en;
  logic [1:0]        proc_row;
  logic [3:0]        proc_key;
  logic              smp, differs;
  logic [3:0]        cnt_inc;
  logic              deb_push;

  logic              push_vld;
  logic [4:0]        push_data;

  assign slot_last = (slot_q == SW'(SCAN_DIV - 1));
  assign col_n     = ~(4'b0001 << col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      col_q  <= 2'd0;
    end else if (slot_last) begin
      slot_q <= '0;
      col_q  <= col_q + 2'd1;
    end else begin
      slot_q <= slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  end

  // Rows latched at the end of each column slot, then walked one key per clock
  // over the first four clocks of the next slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= 4'hF;
      samp_col_q <= 2'd0;
      samp_vld_q <= 1'b0;
    end else if (slot_last) begin
      samp_q     <= sync2_q;
      samp_col_q <= col_q;
      samp_vld_q <= 1'b1;
    end
  end

  assign proc_en  = samp_vld_q && (32'(slot_q) < 32'd4);
  assign proc_row = slot_q[1:0];
  assign proc_key = {samp_col_q, proc_row};
  assign smp      = ~samp_q[proc_row];
  assign differs  = (smp != kd_q[proc_key]);
  assign cnt_inc  = dcnt_q[proc_key] + 4'd1;
  assign deb_push = proc_en && differs && (cnt_inc == 4'(DEBOUNCE_SCANS));

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q <= '0;
      kd_q   <= '0;
    end else if (proc_en) begin
      if (!differs || deb_push) dcnt_q[proc_key] <= 4'd0;
      else                      dcnt_q[proc_key] <= cnt_inc;
      if (deb_push) kd_q[proc_key] <= ~kd_q[proc_key];
    end
  end

  assign keys_down = kd_q;

`ifdef KEY_MATRIX_AUTOREPEAT_EN
  logic        rpt_act_q, rpt_first_q, rpt_pend_q;
  logic [3:0]  rpt_key_q;
  logic [15:0] rpt_cnt_q;
  logic        scan_tick, rpt_emit, rpt_due;

  assign scan_tick = slot_last && (col_q == 2'd3);
  // A due repeat waits in rpt_pend_q until a clock with no debounce push.
  assign rpt_emit  = rpt_pend_q && !deb_push;
  assign rpt_due   = (32'(rpt_cnt_q) + 32'd1) ==
                     (rpt_first_q ? 32'(REPEAT_START) : 32'(REPEAT_PERIOD));

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_act_q   <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_pend_q  <= 1'b0;
      rpt_key_q   <= 4'd0;
      rpt_cnt_q   <= '0;
    end else if (deb_push && smp) begin
      rpt_act_q   <= 1'b1;
      rpt_first_q <= 1'b1;
      rpt_pend_q  <= 1'b0;
      rpt_key_q   <= proc_key;
      rpt_cnt_q   <= '0;
    end else if (deb_push && proc_key == rpt_key_q) begin
      rpt_act_q  <= 1'b0;
      rpt_pend_q <= 1'b0;
    end else begin
      if (rpt_emit) rpt_pend_q <= 1'b0;
      if (scan_tick && rpt_act_q) begin
        if (rpt_due) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b0;
          rpt_pend_q  <= 1'b1;
        end else begin
          rpt_cnt_q <= rpt_cnt_q + 16'd1;
        end
      end
    end
  end

  assign push_vld  = deb_push || rpt_emit;
  assign push_data = deb_push ? {smp, proc_key} : {1'b1, rpt_key_q};
`else
  assign push_vld  = deb_push;
  assign push_data = {smp, proc_key};
`endif

  logic [3:0][4:0] mem_q;
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      cnt_q;
  logic            ovf_q;
  logic            pop, full, acc;

  assign pop  = (cnt_q != 3'd0) && ev.key_ready;
  assign full = (cnt_q == 3'd4);
  // When full, the write slot is the head being popped this clock.
  assign acc  = push_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
      ovf_q <= 1'b0;
    end else begin
      if (acc) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, acc} - {2'b0, pop};
      if (push_vld && !acc) ovf_q <= 1'b1;
    end
  end

  assign ev.key_valid              = (cnt_q != 3'd0);
  assign {ev.key_pressed, ev.key_code} = mem_q[rd_q];
  assign event_overflow            = ovf_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a behavioral 4x4 key matrix.
module tb_key_matrix_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n, row_n;
  logic [15:0] keys_down;
  logic        event_overflow;
  logic [15:0] held = '0;

  key_matrix_scanner_if kif ();

  key_matrix_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_START(3), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .ev(kif.master),
    .keys_down(keys_down), .event_overflow(event_overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_n[c]) row_n = ~held[c*4 +: 4];
  end

  logic [4:0] ev_q[$];
  always @(posedge clk)
    if (!rst && kif.key_valid && kif.key_ready)
      ev_q.push_back({kif.key_pressed, kif.key_code});

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_col;
    int n5, exp5, t;
    kif.key_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(kif.key_valid), 32'd0);
    chk("rst_code", 32'(kif.key_code), 32'd0);
    chk("rst_pressed", 32'(kif.key_pressed), 32'd0);
    chk("rst_keys", 32'(keys_down), 32'd0);
    chk("rst_ovf", 32'(event_overflow), 32'd0);
    rst = 1'b0;

    // Idle column walk
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      chk($sformatf("col_%0d", i), 32'(col_n), 32'(exp_col));
      clks(1);
    end
    clks(48);
    chk("idle_valid", 32'(kif.key_valid), 32'd0);
    chk("idle_keys", 32'(keys_down), 32'd0);
    chk("idle_events", 32'(ev_q.size()), 32'd0);

    // Single key 9 press/release
    kif.key_ready = 1'b1;
    held[9] = 1'b1;
    clks(64);
    chk("k9_keys_dn", 32'(keys_down), 32'h0200);
    chk("k9_n_press", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1) chk("k9_press_ev", 32'(ev_q[0]), 32'h19);
    held[9] = 1'b0;
    clks(64);
    chk("k9_keys_up", 32'(keys_down), 32'h0);
    chk("k9_n_total", 32'(ev_q.size()), 32'd2);
    if (ev_q.size() >= 2) chk("k9_rel_ev", 32'(ev_q[1]), 32'h09);
    ev_q.delete();

    // Bounce: key 6 toggles every scan
    for (int s = 0; s < 10; s++) begin
      held[6] = (s % 2 == 0);
      clks(16);
    end
    held[6] = 1'b0;
    clks(48);
    chk("bounce_events", 32'(ev_q.size()), 32'd0);
    chk("bounce_keys", 32'(keys_down), 32'h0);

    // FIFO fill and overflow
    kif.key_ready = 1'b0;
    held[0] = 1'b1;  clks(64);
    held[3] = 1'b1;  clks(64);
    chk("ff_head_valid", 32'(kif.key_valid), 32'd1);
    chk("ff_head_ev", 32'({kif.key_pressed, kif.key_code}), 32'h10);
    held[0] = 1'b0;  clks(64);
    held[3] = 1'b0;  clks(64);
    chk("ff_no_ovf_yet", 32'(event_overflow), 32'd0);
    held[15] = 1'b1; clks(64);
    chk("ff_ovf", 32'(event_overflow), 32'd1);
    chk("ff_head_stable", 32'({kif.key_pressed, kif.key_code}), 32'h10);
    chk("ff_keys", 32'(keys_down), 32'h8000);
    chk("ff_none_popped", 32'(ev_q.size()), 32'd0);
    kif.key_ready = 1'b1;
    clks(3);
    chk("drain_valid3", 32'(kif.key_valid), 32'd1);
    clks(1);
    chk("drain_valid4", 32'(kif.key_valid), 32'd0);
    chk("drain_n", 32'(ev_q.size()), 32'd4);
    if (ev_q.size() == 4) begin
      chk("drain_ev0", 32'(ev_q[0]), 32'h10);
      chk("drain_ev1", 32'(ev_q[1]), 32'h13);
      chk("drain_ev2", 32'(ev_q[2]), 32'h00);
      chk("drain_ev3", 32'(ev_q[3]), 32'h03);
    end
    clks(32);
    chk("ovf_sticky", 32'(event_overflow), 32'd1);
    ev_q.delete();

    // Reset with events pending and key 0 held
    kif.key_ready = 1'b0;
    held[15] = 1'b0; clks(64);
    held[0] = 1'b1;  clks(64);
    chk("pre_rst_valid", 32'(kif.key_valid), 32'd1);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    chk("post_rst_valid", 32'(kif.key_valid), 32'd0);
    chk("post_rst_keys", 32'(keys_down), 32'h0);
    chk("post_rst_ovf", 32'(event_overflow), 32'd0);
    chk("post_rst_col", 32'(col_n), 32'he);
    kif.key_ready = 1'b1;
    clks(80);
    chk("rearm_n", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1) chk("rearm_ev", 32'(ev_q[0]), 32'h10);
    chk("rearm_keys", 32'(keys_down), 32'h0001);

    // Hold key 5: count press events over ten scans
    held[0] = 1'b0;
    clks(64);
    ev_q.delete();
    held[5] = 1'b1;
    t = 0;
    while (ev_q.size() == 0 && t < 128) begin
      clks(1);
      t++;
    end
    chk("k5_first_seen", 32'(ev_q.size() != 0), 32'd1);
    clks(160);
    n5 = 0;
    foreach (ev_q[i]) if (ev_q[i] == 5'h15) n5++;
`ifdef KEY_MATRIX_AUTOREPEAT_EN
    exp5 = 5;
`else
    exp5 = 1;
`endif
    chk("k5_press_count", 32'(n5), 32'(exp5));
    chk("k5_only_presses", 32'(ev_q.size()), 32'(exp5));
    held[5] = 1'b0;
    clks(80);
    chk("k5_keys_up", 32'(keys_down), 32'h0);
    if (ev_q.size() > 0) chk("k5_last_rel", 32'(ev_q[ev_q.size()-1]), 32'h05);
    else chk("k5_last_rel", 32'hFF, 32'h05);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/key_matrix_scanner.md
KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27000, clocks per column slot (1 ms at 27 MHz); legal range >= 4.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive identical samples needed to accept a key change; legal range 1..15.
REQ-003 SHALL have parameter REPEAT_START, default 500, full scans before first auto-repeat (used only with REQ-031).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 100, full scans between auto-repeats (used only with REQ-031).
REQ-005 clk  input  1  system clock, the single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 col_n  output  4  column strobes, active-low, exactly one low at any time.
REQ-008 row_n  input  4  row sense, active-low, external pull-ups, asynchronous to clk.
REQ-009 key_valid  output  1  event available at head of queue.
REQ-010 key_code  output  4  event key index = col*4 + row.
REQ-011 key_pressed  output  1  1 = press event, 0 = release event.
REQ-012 key_ready  input  1  consumer accepts head event when high with key_valid.
REQ-013 keys_down  output  16  debounced key state bitmap, bit index = key index.
REQ-014 event_overflow  output  1  sticky flag: an event was dropped.

Function
REQ-015 row_n SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Slot counter SHALL count 0..SCAN_DIV-1 and wrap; column index (0..3) SHALL advance by one on each wrap, wrapping 3->0.
REQ-017 col_n SHALL equal the bitwise inverse of (1 << column index).
REQ-018 Rows SHALL be sampled only when slot counter == SCAN_DIV-1 (settling time before column change); sampled bit r is key col*4+r, pressed when low.
REQ-019 Per key, a debounce counter SHALL clear when sample equals keys_down bit, and increment when it differs.
REQ-020 When the counter reaches DEBOUNCE_SCANS, keys_down bit SHALL toggle on the next clock, counter SHALL clear, and one event {key_pressed = new state, key_code} SHALL be pushed.
REQ-021 At most one key is sampled per clock, hence at most one push per clock.
REQ-022 Events SHALL be queued in a 4-entry FIFO in push order.
REQ-023 key_valid SHALL be high iff FIFO non-empty; key_code/key_pressed SHALL present the head entry and be held stable while key_valid && !key_ready.
REQ-024 Pop SHALL occur on a clock where key_valid && key_ready; next entry (if any) SHALL appear the following clock with no bubble.
REQ-025 Push into a full FIFO with simultaneous pop SHALL be accepted; push into a full FIFO without pop SHALL be dropped and set event_overflow.
REQ-026 Push into an empty FIFO SHALL raise key_valid on the next clock (1-cycle latency).
REQ-027 Multiple keys held SHALL be tracked independently; no ghosting suppression.

Reset
REQ-028 While rst high on a clock edge: slot counter 0, column index 0 (col_n = 4'b1110), synchronizer flops 1, all debounce counters 0, keys_down 0, FIFO emptied, key_valid 0, key_code 0, key_pressed 0, event_overflow 0, repeat state cleared.
REQ-029 Reset asserted mid-scan or with events pending SHALL discard all state; keys held through reset SHALL produce fresh press events after reset release and debounce.
REQ-030 event_overflow SHALL clear only by reset.

Configuration
REQ-031 With KEY_MATRIX_AUTOREPEAT_EN defined: the most recently pressed key still held SHALL push an extra press event REPEAT_START full scans after its press event, then every REPEAT_PERIOD full scans until released or another key is pressed; repeat pushes obey REQ-025.
REQ-032 Without KEY_MATRIX_AUTOREPEAT_EN: no repeat logic synthesized; exactly one press and one release event per debounced transition; REQ-003/REQ-004 ignored.

Verification (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_START=3, REPEAT_PERIOD=2; full scan = 16 clocks)
REQ-033 Reset then idle with row_n = 4'hF -> col_n sequence 1110,1101,1011,0111 each held 4 clocks, key_valid stays 0, keys_down = 0.
REQ-034 Hold row 1 low only while col_n = 1011 for 3 full scans, key_ready = 1 -> one event key_code = 9, key_pressed = 1, keys_down = 16'h0200; release -> one event key_code = 9, key_pressed = 0, keys_down = 0.
REQ-035 Bounce: row toggles every other scan for 10 scans -> no events, keys_down unchanged.
REQ-036 key_ready = 0, generate 5 press/release events -> first 4 held in order with head stable, 5th dropped, event_overflow = 1; then key_ready = 1 -> 4 events drained back-to-back, key_valid falls after the 4th.
REQ-037 rst pulse with 2 events queued and key 0 held -> key_valid = 0, keys_down = 0 next clock; key 0 press event reappears after debounce.
REQ-038 With KEY_MATRIX_AUTOREPEAT_EN, hold key 5 for 10 scans -> press events at debounce, +3 scans, +5 scans, +7 scans, +9 scans; without macro -> single press event.
